// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: writeback trace FIFO with PC trigger, valid/ready drain and drop counter
module wb_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          arm,
  input  logic          stop,
  input  logic          trig_en,
  input  logic [15:0]   trig_pc,
  input  logic          in_valid,
  input  logic [15:0]   in_pc,
  input  logic [3:0]    in_reg,
  input  logic [15:0]   in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [15:0]   out_pc,
  output logic [3:0]    out_reg,
  output logic [15:0]   out_data,
  output logic [1:0]    state,
  output logic [AW:0]   count,
  output logic [15:0]   dropped,
  output logic          triggered
);
  typedef enum logic [1:0] {IDLE = 2'b00, ARMED = 2'b01, CAPTURE = 2'b10, BAD = 2'b11} st_t;
  st_t st, nxt;
  logic [35:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic match, push, pop, full, wr, go;
  assign out_valid = count != '0;
  assign {out_pc, out_reg, out_data} = mem[rp];
  assign state = st;
  // push/pop decisions and next state; stop beats arm, illegal state recovers to IDLE
  always_comb begin
    match = st == ARMED && in_valid && in_pc == trig_pc;
    push = (in_valid && st == CAPTURE) || match;
    pop = out_valid && out_ready;
    full = count == (AW+1)'(DEPTH);
    wr = push && (!full || pop);
    go = st == IDLE && arm && !stop;
    nxt = st == BAD ? IDLE :
          (stop && st != IDLE) ? IDLE :
          go ? (trig_en ? ARMED : CAPTURE) :
          match ? CAPTURE : st;
  end
  // state register
  always_ff @(posedge clk) begin
    if (reset) st <= IDLE;
    else st <= nxt;
  end
  // storage cleared on reset so the head reads as zero
  always_ff @(posedge clk) begin
    if (reset) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (wr) mem[wp] <= {in_pc, in_reg, in_data};
  end
  // pointers, occupancy, saturating drop counter and sticky trigger flag
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      dropped <= '0;
      triggered <= 1'b0;
    end else begin
      wp <= wr ? wp + 1'b1 : wp;
      rp <= pop ? rp + 1'b1 : rp;
      count <= count + {{AW{1'b0}}, wr} - {{AW{1'b0}}, pop};
      dropped <= go ? 16'h0 : (push && !wr && dropped != 16'hFFFF) ? dropped + 16'h1 : dropped;
      triggered <= go ? 1'b0 : triggered | match;
    end
  end
endmodule
